// File: rtl/mem_access_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// mem_access_ctrl_pkg
// Shared definitions for the memory access controller: FSM state encodings,
// address/data widths and index limits, and the default access timeout.
// ----------------------------------------------------------------------------
package mem_access_ctrl_pkg;

    localparam int ADDR_W   = 26;
    localparam int DATA_W   = 32;
    localparam int ADDR_MSB = ADDR_W - 1;
    localparam int DATA_MSB = DATA_W - 1;

    localparam int unsigned DEF_TIMEOUT = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_REQ   = 2'b01,
        ST_DONE  = 2'b10,
        ST_FAULT = 2'b11
    } state_t;

endpackage

// File: rtl/mem_timeout_cnt.sv
// ----------------------------------------------------------------------------
// mem_timeout_cnt
// Down-counter that measures how long a memory request has been outstanding.
// It is reloaded whenever no request is in flight and flags terminal count
// on the TIMEOUT-th request cycle.
//
// Ports:
//   i_clk    clock
//   i_rst_n  synchronous active-low reset (clears the count)
//   i_load   reload to TIMEOUT-1 (asserted while no request is outstanding)
//   i_en     request cycle in progress; count down
//   o_tc     terminal count reached during an enabled cycle
// ----------------------------------------------------------------------------
module mem_timeout_cnt
    import mem_access_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_load,
    input  logic i_en,
    output logic o_tc
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= CNT_W'(TIMEOUT - 1);
        end else if (i_en && (r_cnt != '0)) begin
            r_cnt <= r_cnt - CNT_W'(1);
        end
    end

    // Count was loaded with TIMEOUT-1, so zero is seen on the TIMEOUT-th cycle.
    assign o_tc = i_en && (r_cnt == '0);

endmodule

// File: rtl/mem_access_ctrl.sv
// ----------------------------------------------------------------------------
// mem_access_ctrl
// Bridges the processor's level READ/WRITE strobes to a single-request,
// single-ack memory port. One access is issued per strobe assertion; the
// processor holds while o_busy is high.
//
// Build option: define MEM_ACCESS_TIMEOUT_EN to abort requests that receive
// no ack within TIMEOUT cycles (mem_timeout_cnt is only built in that case).
//
// Ports:
//   i_clk, i_rst_n        clock, synchronous active-low reset
//   i_read, i_write       access strobes (level)
//   i_addr, i_data_w      word address and store data
//   o_data_r              registered read data
//   o_busy, o_err         access in flight, access error
//   o_mem_req, o_mem_we   memory request and direction (1 = write)
//   o_mem_addr, o_mem_wdata  registered address and write data
//   i_mem_rdata, i_mem_ack   memory read data and one-cycle completion
//
// state    | meaning
// ST_IDLE  | waiting for a single strobe
// ST_REQ   | request on the memory port, waiting for ack
// ST_DONE  | access complete, waiting for strobes to drop
// ST_FAULT | both strobes or timeout; waiting for strobes to drop
// ----------------------------------------------------------------------------
module mem_access_ctrl
    import mem_access_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_read,
    input  logic              i_write,
    input  logic [ADDR_MSB:0] i_addr,
    input  logic [DATA_MSB:0] i_data_w,
    output logic [DATA_MSB:0] o_data_r,
    output logic              o_busy,
    output logic              o_err,
    output logic              o_mem_req,
    output logic              o_mem_we,
    output logic [ADDR_MSB:0] o_mem_addr,
    output logic [DATA_MSB:0] o_mem_wdata,
    input  logic [DATA_MSB:0] i_mem_rdata,
    input  logic              i_mem_ack
);

    state_t            r_state;
    state_t            w_next_state;
    logic              w_accept;
    logic              w_conflict;
    logic              w_timeout;
    logic              w_in_req;
    logic [DATA_MSB:0] r_data_r;
    logic              r_err;
    logic              r_mem_we;
    logic [ADDR_MSB:0] r_mem_addr;
    logic [DATA_MSB:0] r_mem_wdata;

    assign w_in_req = (r_state == ST_REQ);

`ifdef MEM_ACCESS_TIMEOUT_EN
    mem_timeout_cnt #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout_cnt (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_load  (!w_in_req),
        .i_en    (w_in_req),
        .o_tc    (w_timeout)
    );
`else
    // Requests wait forever; TIMEOUT has no effect in this build.
    assign w_timeout = 1'b0;
    if (TIMEOUT == 0) begin : g_timeout_unused
    end
`endif

    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        w_conflict   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_read && i_write) begin
                    w_conflict   = 1'b1;
                    w_next_state = ST_FAULT;
                end else if (i_read || i_write) begin
                    w_accept     = 1'b1;
                    w_next_state = ST_REQ;
                end
            end
            ST_REQ: begin
                // An ack in the terminal cycle still completes the access.
                if (i_mem_ack) begin
                    w_next_state = ST_DONE;
                end else if (w_timeout) begin
                    w_next_state = ST_FAULT;
                end
            end
            ST_DONE, ST_FAULT: begin
                // Wait for the strobe to drop so a held strobe is not reissued.
                if (!i_read && !i_write) begin
                    w_next_state = ST_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state     <= ST_IDLE;
            r_data_r    <= '0;
            r_err       <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_accept) begin
                r_mem_we    <= i_write;
                r_mem_addr  <= i_addr;
                r_mem_wdata <= i_data_w;
                r_err       <= 1'b0;
            end else if (w_conflict || (w_in_req && !i_mem_ack && w_timeout)) begin
                r_err <= 1'b1;
            end
            if (w_in_req && i_mem_ack && !r_mem_we) begin
                r_data_r <= i_mem_rdata;
            end
        end
    end

    assign o_data_r    = r_data_r;
    assign o_busy      = w_in_req;
    assign o_err       = r_err;
    assign o_mem_req   = w_in_req;
    assign o_mem_we    = r_mem_we;
    assign o_mem_addr  = r_mem_addr;
    assign o_mem_wdata = r_mem_wdata;

endmodule

// File: tb/tb_mem_access_ctrl.sv
module tb_mem_access_ctrl;

    logic        clk;
    logic        i_rst_n;
    logic        i_read;
    logic        i_write;
    logic [25:0] i_addr;
    logic [31:0] i_data_w;
    logic [31:0] o_data_r;
    logic        o_busy;
    logic        o_err;
    logic        o_mem_req;
    logic        o_mem_we;
    logic [25:0] o_mem_addr;
    logic [31:0] o_mem_wdata;
    logic [31:0] i_mem_rdata;
    logic        i_mem_ack;

    int n_cmp;
    int n_bad;

    mem_access_ctrl u_dut (
        .i_clk       (clk),
        .i_rst_n     (i_rst_n),
        .i_read      (i_read),
        .i_write     (i_write),
        .i_addr      (i_addr),
        .i_data_w    (i_data_w),
        .o_data_r    (o_data_r),
        .o_busy      (o_busy),
        .o_err       (o_err),
        .o_mem_req   (o_mem_req),
        .o_mem_we    (o_mem_we),
        .o_mem_addr  (o_mem_addr),
        .o_mem_wdata (o_mem_wdata),
        .i_mem_rdata (i_mem_rdata),
        .i_mem_ack   (i_mem_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Runs 'total' cycles starting at the first negedge after the strobe was
    // sampled. Drives a one-cycle ack at iteration ack_after (0 = never) and
    // reports request cycles, request rising edges and changes of the request
    // fields while the request is up. Returns at the following negedge.
    task automatic run_req(input int ack_after, input int total, input logic [31:0] rdata,
                           output int req_cnt, output int rises, output int changes);
        logic        prev;
        logic        have;
        logic [25:0] a0;
        logic [31:0] w0;
        logic        we0;
        req_cnt = 0; rises = 0; changes = 0; prev = 1'b0; have = 1'b0;
        a0 = '0; w0 = '0; we0 = 1'b0;
        for (int k = 1; k <= total; k++) begin
            if (o_mem_req === 1'b1) begin
                req_cnt++;
                if (!prev) rises++;
                if (!have) begin
                    a0 = o_mem_addr; w0 = o_mem_wdata; we0 = o_mem_we; have = 1'b1;
                end else if (o_mem_addr !== a0 || o_mem_wdata !== w0 || o_mem_we !== we0) begin
                    changes++;
                end
            end
            prev = (o_mem_req === 1'b1);
            if (k == ack_after) begin
                i_mem_ack = 1'b1; i_mem_rdata = rdata;
            end else begin
                i_mem_ack = 1'b0;
            end
            @(negedge clk);
        end
        i_mem_ack = 1'b0;
    endtask

    task automatic test_reset();
        i_rst_n = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++; if (o_mem_req !== 1'b0) begin n_bad++; $display("FAIL reset_mem_req: got %b want 0", o_mem_req); end
        n_cmp++; if (o_mem_we !== 1'b0) begin n_bad++; $display("FAIL reset_mem_we: got %b want 0", o_mem_we); end
        n_cmp++; if (o_busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", o_busy); end
        n_cmp++; if (o_err !== 1'b0) begin n_bad++; $display("FAIL reset_err: got %b want 0", o_err); end
        n_cmp++; if (o_data_r !== 32'h0) begin n_bad++; $display("FAIL reset_data_r: got %h want 0", o_data_r); end
        n_cmp++; if (o_mem_addr !== 26'h0) begin n_bad++; $display("FAIL reset_mem_addr: got %h want 0", o_mem_addr); end
        n_cmp++; if (o_mem_wdata !== 32'h0) begin n_bad++; $display("FAIL reset_mem_wdata: got %h want 0", o_mem_wdata); end
        i_rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_read();
        int rc, rs, ch;
        i_read = 1'b1; i_addr = 26'h0000010;
        @(negedge clk);
        n_cmp++; if (o_mem_we !== 1'b0) begin n_bad++; $display("FAIL read_we: got %b want 0", o_mem_we); end
        run_req(2, 2, 32'hDEADBEEF, rc, rs, ch);
        n_cmp++; if (rc !== 2) begin n_bad++; $display("FAIL read_busy_cycles: got %0d want 2", rc); end
        n_cmp++; if (o_busy !== 1'b0) begin n_bad++; $display("FAIL read_busy_low: got %b want 0", o_busy); end
        n_cmp++; if (o_data_r !== 32'hDEADBEEF) begin n_bad++; $display("FAIL read_data: got %h want deadbeef", o_data_r); end
        n_cmp++; if (o_err !== 1'b0) begin n_bad++; $display("FAIL read_err: got %b want 0", o_err); end
        n_cmp++; if (o_mem_addr !== 26'h0000010) begin n_bad++; $display("FAIL read_addr: got %h want 0000010", o_mem_addr); end
        i_read = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_write();
        int rc, rs, ch;
        i_write = 1'b1; i_addr = 26'h03FFFFF; i_data_w = 32'h12345678;
        @(negedge clk);
        n_cmp++; if (o_mem_we !== 1'b1) begin n_bad++; $display("FAIL write_we: got %b want 1", o_mem_we); end
        n_cmp++; if (o_mem_wdata !== 32'h12345678) begin n_bad++; $display("FAIL write_wdata: got %h want 12345678", o_mem_wdata); end
        n_cmp++; if (o_mem_addr !== 26'h03FFFFF) begin n_bad++; $display("FAIL write_addr: got %h want 03fffff", o_mem_addr); end
        i_data_w = 32'hA5A5A5A5; i_addr = 26'h0;
        run_req(5, 5, 32'hCAFEF00D, rc, rs, ch);
        n_cmp++; if (rc !== 5) begin n_bad++; $display("FAIL write_req_cycles: got %0d want 5", rc); end
        n_cmp++; if (ch !== 0) begin n_bad++; $display("FAIL write_stable: got %0d changes want 0", ch); end
        n_cmp++; if (o_data_r !== 32'hDEADBEEF) begin n_bad++; $display("FAIL write_data_r_held: got %h want deadbeef", o_data_r); end
        n_cmp++; if (o_busy !== 1'b0) begin n_bad++; $display("FAIL write_busy_low: got %b want 0", o_busy); end
        // Stray ack while waiting in DONE with the strobe still high.
        i_mem_ack = 1'b1; i_mem_rdata = 32'hFFFFFFFF;
        @(negedge clk);
        i_mem_ack = 1'b0;
        @(negedge clk);
        n_cmp++; if (o_data_r !== 32'hDEADBEEF) begin n_bad++; $display("FAIL stray_ack_data_r: got %h want deadbeef", o_data_r); end
        n_cmp++; if (o_mem_req !== 1'b0) begin n_bad++; $display("FAIL stray_ack_req: got %b want 0", o_mem_req); end
        i_write = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_held_read();
        int rc, rs, ch;
        i_read = 1'b1; i_addr = 26'h0000020;
        @(negedge clk);
        run_req(2, 8, 32'h0BADF00D, rc, rs, ch);
        n_cmp++; if (rs !== 1) begin n_bad++; $display("FAIL held_read_req_count: got %0d want 1", rs); end
        n_cmp++; if (rc !== 2) begin n_bad++; $display("FAIL held_read_req_cycles: got %0d want 2", rc); end
        n_cmp++; if (o_data_r !== 32'h0BADF00D) begin n_bad++; $display("FAIL held_read_data: got %h want 0badf00d", o_data_r); end
        i_read = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++; if (o_mem_req !== 1'b0) begin n_bad++; $display("FAIL held_read_after: got %b want 0", o_mem_req); end
    endtask

    task automatic test_conflict();
        int rc, rs, ch;
        i_read = 1'b1; i_write = 1'b1; i_addr = 26'h0000033;
        @(negedge clk);
        n_cmp++; if (o_err !== 1'b1) begin n_bad++; $display("FAIL conflict_err: got %b want 1", o_err); end
        n_cmp++; if (o_mem_req !== 1'b0) begin n_bad++; $display("FAIL conflict_req: got %b want 0", o_mem_req); end
        n_cmp++; if (o_busy !== 1'b0) begin n_bad++; $display("FAIL conflict_busy: got %b want 0", o_busy); end
        repeat (2) @(negedge clk);
        n_cmp++; if (o_mem_req !== 1'b0) begin n_bad++; $display("FAIL conflict_req_held: got %b want 0", o_mem_req); end
        i_read = 1'b0; i_write = 1'b0;
        @(negedge clk);
        n_cmp++; if (o_err !== 1'b1) begin n_bad++; $display("FAIL conflict_err_sticky: got %b want 1", o_err); end
        i_read = 1'b1; i_addr = 26'h0000040;
        @(negedge clk);
        n_cmp++; if (o_err !== 1'b0) begin n_bad++; $display("FAIL conflict_err_clear: got %b want 0", o_err); end
        n_cmp++; if (o_mem_req !== 1'b1) begin n_bad++; $display("FAIL conflict_next_req: got %b want 1", o_mem_req); end
        run_req(1, 1, 32'h11112222, rc, rs, ch);
        n_cmp++; if (o_data_r !== 32'h11112222) begin n_bad++; $display("FAIL conflict_next_data: got %h want 11112222", o_data_r); end
        i_read = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        i_read = 1'b1; i_addr = 26'h0000055;
        @(negedge clk);
        n_cmp++; if (o_mem_req !== 1'b1) begin n_bad++; $display("FAIL rst_mid_req_before: got %b want 1", o_mem_req); end
        i_rst_n = 1'b0; i_read = 1'b0;
        @(negedge clk);
        n_cmp++; if ({o_mem_req, o_mem_we, o_busy, o_err} !== 4'b0) begin n_bad++; $display("FAIL rst_mid_flags: got %b want 0000", {o_mem_req, o_mem_we, o_busy, o_err}); end
        n_cmp++; if (o_data_r !== 32'h0) begin n_bad++; $display("FAIL rst_mid_data_r: got %h want 0", o_data_r); end
        n_cmp++; if (o_mem_addr !== 26'h0) begin n_bad++; $display("FAIL rst_mid_addr: got %h want 0", o_mem_addr); end
        i_rst_n = 1'b1; i_mem_ack = 1'b1; i_mem_rdata = 32'h00000099;
        @(negedge clk);
        i_mem_ack = 1'b0;
        @(negedge clk);
        n_cmp++; if (o_data_r !== 32'h0) begin n_bad++; $display("FAIL rst_mid_late_ack: got %h want 0", o_data_r); end
        n_cmp++; if ({o_mem_req, o_busy, o_err} !== 3'b0) begin n_bad++; $display("FAIL rst_mid_after: got %b want 000", {o_mem_req, o_busy, o_err}); end
    endtask

    task automatic test_timeout();
        int rc, rs, ch;
        i_write = 1'b1; i_addr = 26'h0000077; i_data_w = 32'h77777777;
        @(negedge clk);
`ifdef MEM_ACCESS_TIMEOUT_EN
        run_req(0, 20, 32'h0, rc, rs, ch);
        n_cmp++; if (rc !== 16) begin n_bad++; $display("FAIL timeout_req_cycles: got %0d want 16", rc); end
        n_cmp++; if (o_err !== 1'b1) begin n_bad++; $display("FAIL timeout_err: got %b want 1", o_err); end
        n_cmp++; if (o_mem_req !== 1'b0) begin n_bad++; $display("FAIL timeout_req_low: got %b want 0", o_mem_req); end
`else
        run_req(0, 120, 32'h0, rc, rs, ch);
        n_cmp++; if (rc !== 120) begin n_bad++; $display("FAIL no_timeout_req_cycles: got %0d want 120", rc); end
        n_cmp++; if (o_mem_req !== 1'b1) begin n_bad++; $display("FAIL no_timeout_req_held: got %b want 1", o_mem_req); end
        n_cmp++; if (o_err !== 1'b0) begin n_bad++; $display("FAIL no_timeout_err: got %b want 0", o_err); end
        i_mem_ack = 1'b1;
        @(negedge clk);
        i_mem_ack = 1'b0;
        n_cmp++; if (o_busy !== 1'b0) begin n_bad++; $display("FAIL no_timeout_ack_done: got %b want 0", o_busy); end
`endif
        i_write = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        n_cmp = 0; n_bad = 0;
        i_rst_n = 1'b0; i_read = 1'b0; i_write = 1'b0;
        i_addr = '0; i_data_w = '0; i_mem_rdata = '0; i_mem_ack = 1'b0;
        test_reset();
        test_read();
        test_write();
        test_held_read();
        test_conflict();
        test_reset_mid();
        test_timeout();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
